// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption core. It expands the key forward to round key 10, then runs one inverse round per clock while stepping the key schedule backwards.
// Optional build macro AES_DEC_KEY_CACHE_EN keeps the last key and its round key 10, so a repeated key skips the forward expansion.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// KEXP  | forward key expansion, one round key per edge
// ROUND | inverse rounds, rk stepped backwards each edge
// DONE  | plaintext presented, waiting for out_ready
module aes128_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q;
    logic [127:0] rk_q;
    logic [127:0] st_q;
    logic [127:0] out_data_q;
    logic         out_valid_q;
    logic         cache_hit;
    logic [127:0] rk_fwd, rk_prev, round_out;

    // GF(2^8) arithmetic, modulus x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h0};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = rk[31:0]  ^ rk[63:32];
        p2 = rk[63:32] ^ rk[95:64];
        p1 = rk[95:64] ^ rk[127:96];
        p0 = rk[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte i sits at bits 127-8i; row = i%4, column = i/4
    function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        int           r, c, src;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            r   = i % 4;
            c   = i / 4;
            src = r + 4 * ((c + 4 - r) % 4);
            t[127-8*i -: 8] = inv_sbox(st[127-8*src -: 8]);
        end
        t = t ^ rk;
        if (!last) begin
            for (int k = 0; k < 4; k++) begin
                t[127-32*k -: 32] = inv_mix_col(t[127-32*k -: 32]);
            end
        end
        return t;
    endfunction

    assign rk_fwd    = key_fwd(rk_q, rcon(rnd_q));
    assign rk_prev   = key_inv(rk_q, rcon(rnd_q));
    assign round_out = inv_round(st_q, rk_prev, rnd_q == 4'd1);

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_cache_q;
    logic [127:0] rk10_cache_q;
    logic         cache_vld_q;

    assign cache_hit = cache_vld_q && (in_key == key_cache_q);

    // key_cache is overwritten at accept, so the entry is invalid until rk10 lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cache_q  <= '0;
            rk10_cache_q <= '0;
            cache_vld_q  <= 1'b0;
        end else if (state_q == IDLE && in_valid && !cache_hit) begin
            key_cache_q <= in_key;
            cache_vld_q <= 1'b0;
        end else if (state_q == KEXP && rnd_q == 4'd10) begin
            rk10_cache_q <= rk_fwd;
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = cache_hit ? ROUND : KEXP;
            KEXP:    if (rnd_q == 4'd10) state_d = ROUND;
            ROUND:   if (rnd_q == 4'd1) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // st_q holds the ciphertext during KEXP and the round state afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q       <= 4'd0;
            rk_q        <= '0;
            st_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifdef AES_DEC_KEY_CACHE_EN
                        if (cache_hit) begin
                            st_q  <= in_data ^ rk10_cache_q;
                            rk_q  <= rk10_cache_q;
                            rnd_q <= 4'd10;
                        end else begin
                            st_q  <= in_data;
                            rk_q  <= in_key;
                            rnd_q <= 4'd1;
                        end
`else
                        st_q  <= in_data;
                        rk_q  <= in_key;
                        rnd_q <= 4'd1;
`endif
                    end
                end
                KEXP: begin
                    rk_q <= rk_fwd;
                    if (rnd_q == 4'd10) begin
                        st_q  <= st_q ^ rk_fwd;
                        rnd_q <= 4'd10;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ROUND: begin
                    st_q  <= round_out;
                    rk_q  <= rk_prev;
                    rnd_q <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        out_data_q  <= round_out;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter using published AES-128 vectors.
// Expected plaintext and latency are queued at accept and checked when out_valid rises.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    aes128_decrypt_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] E_CT   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] E_PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] m_key;
    bit           m_vld = 1'b0;
`endif

    // Latency model: repeated key hits the cache only when the cache build is enabled
    function automatic int exp_lat(input logic [127:0] key);
        int l;
        l = 20;
`ifdef AES_DEC_KEY_CACHE_EN
        if (m_vld && key == m_key) l = 10;
        m_key = key;
        m_vld = 1'b1;
`endif
        return l;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
`ifdef AES_DEC_KEY_CACHE_EN
        m_vld = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Caller guarantees the DUT is idle; returns cycle stamp of the accept edge
    task automatic start_block(input logic [127:0] ct, input logic [127:0] key,
                               input logic [127:0] pt, output int t_acc);
        exp_t e;
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t_acc    = cyc;
        e.data   = pt;
        e.lat    = exp_lat(key);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        ok = out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = C1_CT;
        in_key   = C1_KEY;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        tests++;
        if (out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_idle got=%b want=1", in_ready); end
    endtask

    task automatic test_vector(input string name, input logic [127:0] ct,
                               input logic [127:0] key, input logic [127:0] pt);
        int   t;
        bit   ok;
        exp_t e;
        start_block(ct, key, pt, t);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL %s busy got=%b want=0", name, in_ready); end
        wait_valid(40, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL %s timeout out_valid=%b want=1", name, out_valid);
        end else begin
            e = sb.pop_front();
            tests++;
            if (out_data !== e.data) begin fails++; $display("FAIL %s data got=%h want=%h", name, out_data, e.data); end
            tests++;
            if (cyc - t !== e.lat) begin fails++; $display("FAIL %s latency got=%0d want=%0d", name, cyc - t, e.lat); end
        end
        handshake();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL %s release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cts[4];
        logic [127:0] keys[4];
        logic [127:0] pts[4];
        int   t;
        bit   ok;
        exp_t e;
        cts  = '{C1_CT, B_CT, E_CT, Z_CT};
        keys = '{C1_KEY, B_KEY, B_KEY, 128'h0};
        pts  = '{C1_PT, B_PT, E_PT, 128'h0};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_block(cts[k], keys[k], pts[k], t);
            wait_valid(40, ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL b2b%0d timeout out_valid=%b want=1", k, out_valid);
            end else begin
                e = sb.pop_front();
                tests++;
                if (out_data !== e.data) begin fails++; $display("FAIL b2b%0d data got=%h want=%h", k, out_data, e.data); end
                tests++;
                if (cyc - t !== e.lat) begin fails++; $display("FAIL b2b%0d latency got=%0d want=%0d", k, cyc - t, e.lat); end
            end
            @(posedge clk);
            #1;
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++; $display("FAIL b2b%0d turnaround in_ready=%b out_valid=%b want 1/0", k, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int           t;
        bit           ok;
        exp_t         e;
        logic [127:0] held;
        start_block(C1_CT, C1_KEY, C1_PT, t);
        wait_valid(40, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_first timeout out_valid=%b want=1", out_valid); end
        e = sb.pop_front();
        tests++;
        if (out_data !== e.data) begin fails++; $display("FAIL bp_first data got=%h want=%h", out_data, e.data); end
        held     = out_data;
        in_valid = 1'b1;
        in_data  = B_CT;
        in_key   = B_KEY;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d data=%h valid=%b in_ready=%b want %h/1/0", i, out_data, out_valid, in_ready, held);
            end
        end
        handshake();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t        = cyc;
        e.data   = B_PT;
        e.lat    = exp_lat(B_KEY);
        sb.push_back(e);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_second_accept in_ready=%b want=0", in_ready); end
        wait_valid(40, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL bp_second timeout out_valid=%b want=1", out_valid);
        end else begin
            e = sb.pop_front();
            tests++;
            if (out_data !== e.data) begin fails++; $display("FAIL bp_second data got=%h want=%h", out_data, e.data); end
            tests++;
            if (cyc - t !== e.lat) begin fails++; $display("FAIL bp_second latency got=%0d want=%0d", cyc - t, e.lat); end
        end
        handshake();
    endtask

    task automatic test_reset_mid_round();
        int t;
        bit saw;
        do_reset();
        start_block(C1_CT, C1_KEY, C1_PT, t);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        #1 rst_n = 1'b0;
        sb.delete();
`ifdef AES_DEC_KEY_CACHE_EN
        m_vld = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        if (out_valid) saw = 1'b1;
        tests++;
        if (in_ready !== 1'b1 || out_data !== 128'h0) begin
            fails++; $display("FAIL abort_state in_ready=%b out_data=%h want 1/0", in_ready, out_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        tests++;
        if (saw !== 1'b0) begin fails++; $display("FAIL abort_no_output saw_valid=%b want=0", saw); end
        test_vector("resend_c1", C1_CT, C1_KEY, C1_PT);
    endtask

    task automatic test_isolation();
        int   t;
        bit   ok;
        exp_t e;
        start_block(C1_CT, C1_KEY, C1_PT, t);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            ok = out_valid;
        end
        in_data = C1_CT;
        in_key  = C1_KEY;
        tests++;
        if (!ok) begin
            fails++; $display("FAIL iso timeout out_valid=%b want=1", out_valid);
        end else begin
            e = sb.pop_front();
            tests++;
            if (out_data !== e.data) begin fails++; $display("FAIL iso data got=%h want=%h", out_data, e.data); end
            tests++;
            if (cyc - t !== e.lat) begin fails++; $display("FAIL iso latency got=%0d want=%0d", cyc - t, e.lat); end
        end
        handshake();
    endtask

`ifdef AES_DEC_KEY_CACHE_EN
    task automatic test_cache();
        do_reset();
        test_vector("cache_c1_miss", C1_CT, C1_KEY, C1_PT);
        test_vector("cache_c1_hit", C1_CT, C1_KEY, C1_PT);
        test_vector("cache_b_miss", B_CT, B_KEY, B_PT);
        test_vector("cache_c1_again", C1_CT, C1_KEY, C1_PT);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        test_reset();
        test_vector("fips_c1", C1_CT, C1_KEY, C1_PT);
        test_vector("fips_appb", B_CT, B_KEY, B_PT);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_round();
        test_isolation();
`ifdef AES_DEC_KEY_CACHE_EN
        test_cache();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
